// File: rtl/irig_width_encode.sv
// IRIG-B pulse-width encoder.
// Each symbol from a one-entry holding buffer becomes one bit period of CYCLES_BIT cycles:
// irigb is high for the symbol's width (ZERO/ONE/MARK), then low for the rest of the period.
// Back-to-back symbols produce gapless bits; an empty buffer at period end raises underrun.
module irig_width_encode #(
  parameter int unsigned CYCLES_ZERO = 20000,
  parameter int unsigned CYCLES_ONE  = 50000,
  parameter int unsigned CYCLES_MARK = 80000,
  parameter int unsigned CYCLES_BIT  = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sym_valid,
  input  logic [1:0] sym_type,
  output logic       sym_ready,
  output logic       irigb,
  output logic       bit_start,
  output logic       underrun,
  output logic       busy
);

  localparam logic [16:0] WidthZero = 17'(CYCLES_ZERO);
  localparam logic [16:0] WidthOne  = 17'(CYCLES_ONE);
  localparam logic [16:0] WidthMark = 17'(CYCLES_MARK);
  localparam logic [16:0] LastCnt   = 17'(CYCLES_BIT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StHigh,
    StLow
  } state_e;

  state_e      state_q, state_d;
  logic [16:0] cnt_q, cnt_d;
  logic [16:0] width_q, width_d;
  logic        buf_full_q, buf_full_d;
  logic [1:0]  buf_sym_q, buf_sym_d;
  logic        irigb_q, irigb_d;
  logic        bit_start_q, bit_start_d;
  logic        underrun_q, underrun_d;
  logic        accept;
  logic        load;

  // Reserved code 11 falls through to the ZERO width.
  function automatic logic [16:0] width_of(input logic [1:0] t);
    case (t)
      2'b01:   width_of = WidthOne;
      2'b10:   width_of = WidthMark;
      default: width_of = WidthZero;
    endcase
  endfunction

  // Next-state logic for the bit sequencer and the holding buffer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    width_d     = width_q;
    irigb_d     = irigb_q;
    bit_start_d = 1'b0;
    underrun_d  = 1'b0;
    load        = 1'b0;

    unique case (state_q)
      StIdle: begin
        irigb_d = 1'b0;
        cnt_d   = '0;
        if (buf_full_q) begin
          load = 1'b1;
        end
      end
      StHigh: begin
        cnt_d = cnt_q + 17'd1;
        // Falling on the edge where cnt reaches width gives exactly width high cycles.
        if (cnt_q == width_q - 17'd1) begin
          state_d = StLow;
          irigb_d = 1'b0;
        end
      end
      StLow: begin
        if (cnt_q == LastCnt) begin
          // Buffer state before this edge decides; a symbol arriving now waits for IDLE.
          if (buf_full_q) begin
            load = 1'b1;
          end else begin
            underrun_d = 1'b1;
            state_d    = StIdle;
            cnt_d      = '0;
            irigb_d    = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 17'd1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
        irigb_d = 1'b0;
      end
    endcase

    if (load) begin
      state_d     = StHigh;
      cnt_d       = '0;
      width_d     = width_of(buf_sym_q);
      irigb_d     = 1'b1;
      bit_start_d = 1'b1;
    end
  end

  assign accept     = sym_valid & ~buf_full_q;
  assign buf_full_d = (buf_full_q & ~load) | accept;
  assign buf_sym_d  = accept ? sym_type : buf_sym_q;

  // State and buffer registers; reset aborts any bit and drops the buffered symbol.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      width_q     <= WidthZero;
      buf_full_q  <= 1'b0;
      buf_sym_q   <= 2'b00;
      irigb_q     <= 1'b0;
      bit_start_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      width_q     <= width_d;
      buf_full_q  <= buf_full_d;
      buf_sym_q   <= buf_sym_d;
      irigb_q     <= irigb_d;
      bit_start_q <= bit_start_d;
      underrun_q  <= underrun_d;
    end
  end

  // Output decode.
  always_comb begin
    sym_ready = ~buf_full_q;
    irigb     = irigb_q;
    bit_start = bit_start_q;
    underrun  = underrun_q;
    busy      = (state_q != StIdle);
  end

endmodule

// File: tb/tb_irig_width_encode.sv
// Bench for irig_width_encode with scaled-down widths.
// A bit-level model (age within the current bit, active width) is compared on every negedge;
// directed scenarios pin high times, bit spacing and underrun timing with literal values,
// and a width decoder checks a random loopback stream.
module tb_irig_width_encode;

  localparam int unsigned CZ = 3;
  localparam int unsigned CO = 5;
  localparam int unsigned CM = 8;
  localparam int unsigned CB = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sym_valid = 1'b0;
  logic [1:0] sym_type = 2'b00;
  logic       sym_ready, irigb, bit_start, underrun, busy;

  irig_width_encode #(
    .CYCLES_ZERO(CZ),
    .CYCLES_ONE (CO),
    .CYCLES_MARK(CM),
    .CYCLES_BIT (CB)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sym_valid(sym_valid),
    .sym_type (sym_type),
    .sym_ready(sym_ready),
    .irigb    (irigb),
    .bit_start(bit_start),
    .underrun (underrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  function automatic int width_of(input logic [1:0] t);
    case (t)
      2'd1:    return CO;
      2'd2:    return CM;
      default: return CZ;
    endcase
  endfunction

  // Model: one buffered symbol, and the current bit described by its age and width.
  bit         m_full = 0, m_active = 0, m_bs = 0, m_ur = 0;
  logic [1:0] m_sym = 0;
  int         m_age = 0, m_width = 0;

  initial begin : model
    bit acc, start;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_full = 0; m_active = 0; m_bs = 0; m_ur = 0; m_age = 0; m_width = 0;
      end else begin
        acc   = sym_valid && !m_full;
        start = 0;
        m_bs  = 0;
        m_ur  = 0;
        if (m_active) begin
          if (m_age == CB - 1) begin
            if (m_full) start = 1;
            else begin
              m_active = 0;
              m_ur     = 1;
            end
          end else begin
            m_age++;
          end
        end else if (m_full) begin
          start = 1;
        end
        if (start) begin
          m_active = 1;
          m_age    = 0;
          m_width  = width_of(m_sym);
          m_full   = 0;
          m_bs     = 1;
        end
        if (acc) begin
          m_full = 1;
          m_sym  = sym_type;
        end
      end
    end
  end

  // Per-cycle compare plus waveform logging and width decoding.
  int         cyc = 0;
  int         last_rise = 0;
  logic       prev_irigb = 1'b0;
  int         hi_q[$], rise_q[$], ur_q[$];
  logic [1:0] dec_q[$];

  initial begin : monitor
    int hi;
    forever begin
      @(negedge clk);
      cyc++;
      chk("irigb", irigb, (m_active && m_age < m_width));
      chk("busy", busy, m_active);
      chk("bit_start", bit_start, m_bs);
      chk("underrun", underrun, m_ur);
      chk("sym_ready", sym_ready, !m_full);
      if (irigb === 1'b1 && prev_irigb === 1'b0) begin
        last_rise = cyc;
        rise_q.push_back(cyc);
      end
      if (irigb === 1'b0 && prev_irigb === 1'b1) begin
        hi = cyc - last_rise;
        hi_q.push_back(hi);
        if (hi <= (CZ + CO) / 2) dec_q.push_back(2'd0);
        else if (hi <= (CO + CM) / 2) dec_q.push_back(2'd1);
        else dec_q.push_back(2'd2);
      end
      if (underrun === 1'b1) ur_q.push_back(cyc);
      prev_irigb = irigb;
    end
  end

  task automatic clear_logs();
    hi_q.delete();
    rise_q.delete();
    ur_q.delete();
    dec_q.delete();
  endtask

  // Called just after a negedge; returns just after the negedge following acceptance.
  task automatic send(input logic [1:0] t);
    int n;
    n = 0;
    sym_valid = 1'b1;
    sym_type  = t;
    while (sym_ready !== 1'b1 && n < 5 * CB) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5 * CB) chk("send_timeout", 1, 0);
    @(negedge clk);
    sym_valid = 1'b0;
  endtask

  task automatic wait_rise();
    int n;
    n = 0;
    while (irigb !== 1'b1 && n < 5 * CB) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5 * CB) chk("rise_timeout", 1, 0);
  endtask

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  logic [1:0] sent_q[$];

  initial begin : stim
    logic [1:0] t;
    repeat (2) @(negedge clk);
    chk("reset_sym_ready", sym_ready, 1);
    chk("reset_irigb", irigb, 0);
    chk("reset_busy", busy, 0);
    rst_n = 1'b1;

    // Single ZERO: high 3, underrun at period end, then idle.
    clear_logs();
    send(2'd0);
    repeat (3 * CB) @(negedge clk);
    chk("zero_hi_count", hi_q.size(), 1);
    chk("zero_hi", qat(hi_q, 0), 3);
    chk("zero_ur_count", ur_q.size(), 1);
    chk("zero_ur_time", qat(ur_q, 0) - qat(rise_q, 0), 10);
    chk("zero_idle", busy, 0);

    // Stream MARK, ONE, ZERO with valid held: gapless bits 10 apart.
    clear_logs();
    send(2'd2);
    send(2'd1);
    send(2'd0);
    repeat (3 * CB) @(negedge clk);
    chk("stream_bits", rise_q.size(), 3);
    chk("stream_hi0", qat(hi_q, 0), 8);
    chk("stream_hi1", qat(hi_q, 1), 5);
    chk("stream_hi2", qat(hi_q, 2), 3);
    chk("stream_sp01", qat(rise_q, 1) - qat(rise_q, 0), 10);
    chk("stream_sp12", qat(rise_q, 2) - qat(rise_q, 1), 10);
    chk("stream_ur_count", ur_q.size(), 1);
    chk("stream_ur_time", qat(ur_q, 0) - qat(rise_q, 2), 10);

    // Symbol arriving on the period-end edge with an empty buffer: 11-cycle spacing.
    clear_logs();
    send(2'd0);
    wait_rise();
    repeat (CB - 1) @(negedge clk);
    send(2'd1);
    repeat (3 * CB) @(negedge clk);
    chk("pend_ur_count", ur_q.size(), 2);
    chk("pend_ur_time", qat(ur_q, 0) - qat(rise_q, 0), 10);
    chk("pend_spacing", qat(rise_q, 1) - qat(rise_q, 0), 11);
    chk("pend_hi1", qat(hi_q, 1), 5);

    // Reserved code encodes as ZERO.
    clear_logs();
    send(2'd3);
    repeat (3 * CB) @(negedge clk);
    chk("rsv_hi", qat(hi_q, 0), 3);
    chk("rsv_dec", (dec_q.size() > 0) ? dec_q[0] : 2'd3, 0);

    // Reset mid-MARK with ONE buffered: immediate abort, buffered symbol dropped.
    clear_logs();
    send(2'd2);
    send(2'd1);
    wait_rise();
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_irigb", irigb, 0);
    chk("rst_sym_ready", sym_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_bit_start", bit_start, 0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
    repeat (3 * CB) @(negedge clk);
    chk("rst_no_bit", rise_q.size(), 0);

    // Random loopback through the width decoder.
    clear_logs();
    sent_q.delete();
    for (int i = 0; i < 100; i++) begin
      t = 2'($urandom_range(0, 3));
      sent_q.push_back((t == 2'd3) ? 2'd0 : t);
      send(t);
    end
    repeat (3 * CB) @(negedge clk);
    chk("loop_count", dec_q.size(), 100);
    for (int i = 0; i < 100; i++) begin
      chk($sformatf("loop_sym%0d", i), (i < dec_q.size()) ? dec_q[i] : 2'd3, sent_q[i]);
    end
    chk("loop_ur_count", ur_q.size(), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
